execute_result_skid: RTL and testbench
======================================

// Module: execute_result_skid
// PURPOSE
// - Execute-stage output buffer directly downstream of execute_mul (and the sibling ALU units).
// - Captures a unit result (32b data, 5b flags) plus writeback control and PC.
// - Presents the result to the writeback stage through a 2-entry skid buffer
//   using the core's VALID/LOCK handshake.
// - Owns the architectural FLAGS register, committed on departure.
// - Drives a forwarding tap from the youngest held entry.
// PARAMETERS
// - P_DATA_W   32   result data width
// - P_FLAG_W   5    flag width {SF,OF,CF,PF,ZF}; order matches the execute unit outputs
// - P_REG_W    5    destination register index width
// PORTS
// - iCLOCK          in   1         core clock; all state updates on rising edge
// - iRESET_SYNC     in   1         synchronous reset, active-high
// - iFLUSH          in   1         pipeline flush (branch miss/exception) from the later stage
// - iPREVIOUS_VALID in   1         upstream result valid
// - oPREVIOUS_LOCK  out  1         stall upstream; registered
// - iPREVIOUS_DATA  in   P_DATA_W  unit result (e.g. execute_mul oDATA)
// - iPREVIOUS_FLAGS in   P_FLAG_W  unit flags (e.g. execute_mul oFLAGS)
// - iPREVIOUS_DEST  in   P_REG_W   destination GR index
// - iPREVIOUS_WB    in   1         write GR enable
// - iPREVIOUS_FWB   in   1         write FLAGS enable
// - iPREVIOUS_PC    in   32        instruction PC
// - oNEXT_VALID     out  1         head entry valid
// - iNEXT_LOCK      in   1         downstream stall
// - oNEXT_DATA/FLAGS/DEST/WB/FWB/PC  out  as above   head-entry payload
// - oFLAGS_R        out  P_FLAG_W  architectural FLAGS register
// - oFWD_VALID      out  1         forwarding tap valid
// - oFWD_DEST       out  P_REG_W   forwarding destination
// - oFWD_DATA       out  P_DATA_W  forwarding data
// BEHAVIOUR
// - Reset (iRESET_SYNC=1 at edge): count=0; every output and payload register=0
//   (oNEXT_VALID=0, oPREVIOUS_LOCK=0, oFLAGS_R=5'h00, oFWD_VALID=0).
//   Reset mid-transfer drops all held entries with no flag commit.
// - Upstream accept: iPREVIOUS_VALID && !oPREVIOUS_LOCK.
// - Downstream depart: oNEXT_VALID && !iNEXT_LOCK.
// - Storage: head = entry0, skid = entry1; count in {0,1,2}.
// - States:
//   - EMPTY (count 0): accept -> ONE, head<=in.
//   - ONE (count 1):
//     - accept and depart -> ONE, head<=in.
//     - accept only -> FULL, skid<=in.
//     - depart only -> EMPTY.
//   - FULL (count 2): no accept possible; depart -> ONE, head<=skid.
// - oPREVIOUS_LOCK = (count==2), taken directly from the state register. The skid entry
//   absorbs the one beat sent while downstream stalls.
// - oNEXT_VALID = (count!=0); oNEXT_* = head payload. Latency: input accepted at edge N
//   appears on oNEXT_* after edge N, i.e. 1 cycle, when buffer not FULL.
// - FLAGS commit: on depart with head FWB=1, oFLAGS_R <= head FLAGS at the same edge.
//   No commit when FWB=0.
// - Flush: at the edge with iFLUSH=1, count->0 and all entries are discarded; the
//   iPREVIOUS beat in that cycle is dropped. A head departing in the flush cycle is
//   committed: the transfer completed and the entry is older than the flush source.
// - Forwarding: youngest held entry (skid if FULL, else head). oFWD_VALID = count!=0 &&
//   youngest.WB. Dest/data are zero when oFWD_VALID=0.
// - No overflow: upstream beats while locked are ignored (protocol violation; assertion).
// STRUCTURE
// - core_pkg holds:
//   - typedef exe_result_t {data, flags, dest, wb, fwb, pc};
//   - the P_* width constants;
//   - the FLAGS bit-index constants (FLAG_SF..FLAG_ZF).
// - One sub-module, execute_result_entry: single load-enabled exe_result_t register with
//   sync clear. Instantiated twice (head, skid).
// - Count FSM, mux select and FLAGS register live in the top level.
// TESTING
// - Reset: assert iRESET_SYNC 2 cycles with iPREVIOUS_VALID=1 -> oNEXT_VALID=0,
//   oPREVIOUS_LOCK=0, oFLAGS_R=0.
// - Streaming: beat per cycle, iNEXT_LOCK=0, data 1,2,3 -> oNEXT_DATA 1,2,3 one cycle
//   later each; lock never asserts.
// - Skid: iNEXT_LOCK=1 while sending A=0x11,B=0x22 -> lock=1 after B; release -> A then B
//   out in order; nothing lost or duplicated.
// - Flags: mul result 0xFFFF_FFFF*2 low, flags 5'b10101, FWB=1 departs -> oFLAGS_R=5'b10101;
//   next entry FWB=0 -> unchanged.
// - Flush: FULL buffer plus iPREVIOUS_VALID, iFLUSH=1, iNEXT_LOCK=1 -> count 0 next cycle;
//   oFLAGS_R unchanged; oFWD_VALID=0.
// - Forwarding: head dest=3 WB=1, skid dest=7 WB=0 -> oFWD_VALID=0; after head departs
//   and a new dest=9 WB=1 enters -> oFWD_DEST=9.

Source files
------------

// File: rtl/core_pkg.sv
// Shared execute-stage types and widths: result payload struct, FLAGS bit positions,
// and the skid buffer occupancy states.
package core_pkg;

    localparam int P_DATA_W = 32;
    localparam int P_FLAG_W = 5;
    localparam int P_REG_W  = 5;

    // FLAGS layout {SF,OF,CF,PF,ZF}, same order the execute units emit
    localparam int FLAG_SF = 4;
    localparam int FLAG_OF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 0;

    typedef struct packed {
        logic [P_DATA_W-1:0] data;
        logic [P_FLAG_W-1:0] flags;
        logic [P_REG_W-1:0]  dest;
        logic                wb;
        logic                fwb;
        logic [31:0]         pc;
    } exe_result_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/execute_result_entry.sv
// One buffered execute result: load-enabled register with synchronous clear.
// Clear (reset or flush) wins over load.
module execute_result_entry
    import core_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  exe_result_t i_d,
    output exe_result_t o_q
);

    exe_result_t r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/execute_result_skid.sv
// Execute-stage result buffer: 2-entry skid (head/skid) on the VALID/LOCK handshake,
// owner of the architectural FLAGS register and source of the forwarding tap.
//
// state    | meaning
// ST_EMPTY | nothing held, head and skid cleared
// ST_ONE   | head holds the oldest result, skid unused
// ST_FULL  | head and skid both hold results, upstream locked
module execute_result_skid #(
    parameter int P_DATA_W = core_pkg::P_DATA_W,
    parameter int P_FLAG_W = core_pkg::P_FLAG_W,
    parameter int P_REG_W  = core_pkg::P_REG_W
)(
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    input  logic                iFLUSH,
    input  logic                iPREVIOUS_VALID,
    output logic                oPREVIOUS_LOCK,
    input  logic [P_DATA_W-1:0] iPREVIOUS_DATA,
    input  logic [P_FLAG_W-1:0] iPREVIOUS_FLAGS,
    input  logic [P_REG_W-1:0]  iPREVIOUS_DEST,
    input  logic                iPREVIOUS_WB,
    input  logic                iPREVIOUS_FWB,
    input  logic [31:0]         iPREVIOUS_PC,
    output logic                oNEXT_VALID,
    input  logic                iNEXT_LOCK,
    output logic [P_DATA_W-1:0] oNEXT_DATA,
    output logic [P_FLAG_W-1:0] oNEXT_FLAGS,
    output logic [P_REG_W-1:0]  oNEXT_DEST,
    output logic                oNEXT_WB,
    output logic                oNEXT_FWB,
    output logic [31:0]         oNEXT_PC,
    output logic [P_FLAG_W-1:0] oFLAGS_R,
    output logic                oFWD_VALID,
    output logic [P_REG_W-1:0]  oFWD_DEST,
    output logic [P_DATA_W-1:0] oFWD_DATA
);
    import core_pkg::*;

    skid_state_t         r_state;
    logic [P_FLAG_W-1:0] r_flags;

    exe_result_t w_in;
    exe_result_t w_head;
    exe_result_t w_skid;
    exe_result_t w_head_d;
    exe_result_t w_young;
    logic        w_accept;
    logic        w_depart;
    logic        w_head_load;
    logic        w_head_clr;
    logic        w_skid_load;
    logic        w_skid_clr;

    assign w_in = '{data:  iPREVIOUS_DATA,
                    flags: iPREVIOUS_FLAGS,
                    dest:  iPREVIOUS_DEST,
                    wb:    iPREVIOUS_WB,
                    fwb:   iPREVIOUS_FWB,
                    pc:    iPREVIOUS_PC};

    assign w_accept = iPREVIOUS_VALID && (r_state != ST_FULL);
    assign w_depart = (r_state != ST_EMPTY) && !iNEXT_LOCK;

    // Flush reaches the entries through the clear inputs, which dominate any load.
    always_comb begin
        w_head_load = 1'b0;
        w_skid_load = 1'b0;
        w_head_clr  = iFLUSH;
        w_skid_clr  = iFLUSH;
        w_head_d    = w_in;
        case (r_state)
            ST_EMPTY: w_head_load = w_accept;
            ST_ONE: begin
                w_head_load = w_accept && w_depart;
                w_skid_load = w_accept && !w_depart;
                w_head_clr  = iFLUSH || (w_depart && !w_accept);
            end
            ST_FULL: begin
                w_head_load = w_depart;
                w_head_d    = w_skid;
                w_skid_clr  = iFLUSH || w_depart;
            end
            default: ;
        endcase
    end

    execute_result_entry u_head (
        .i_clk  (iCLOCK),
        .i_rst  (iRESET_SYNC),
        .i_clr  (w_head_clr),
        .i_load (w_head_load),
        .i_d    (w_head_d),
        .o_q    (w_head)
    );

    execute_result_entry u_skid (
        .i_clk  (iCLOCK),
        .i_rst  (iRESET_SYNC),
        .i_clr  (w_skid_clr),
        .i_load (w_skid_load),
        .i_d    (w_in),
        .o_q    (w_skid)
    );

    // A head leaving in the flush cycle still commits: it is older than the flush source.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state <= ST_EMPTY;
            r_flags <= '0;
        end else begin
            if (w_depart && w_head.fwb) begin
                r_flags <= w_head.flags;
            end
            if (iFLUSH) begin
                r_state <= ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: if (w_accept) r_state <= ST_ONE;
                    ST_ONE: begin
                        if (w_accept && !w_depart) begin
                            r_state <= ST_FULL;
                        end else if (!w_accept && w_depart) begin
                            r_state <= ST_EMPTY;
                        end
                    end
                    ST_FULL:  if (w_depart) r_state <= ST_ONE;
                    default:  r_state <= ST_EMPTY;
                endcase
            end
        end
    end

    assign oPREVIOUS_LOCK = (r_state == ST_FULL);
    assign oNEXT_VALID    = (r_state != ST_EMPTY);
    assign oNEXT_DATA     = w_head.data;
    assign oNEXT_FLAGS    = w_head.flags;
    assign oNEXT_DEST     = w_head.dest;
    assign oNEXT_WB       = w_head.wb;
    assign oNEXT_FWB      = w_head.fwb;
    assign oNEXT_PC       = w_head.pc;
    assign oFLAGS_R       = r_flags;

    assign w_young    = (r_state == ST_FULL) ? w_skid : w_head;
    assign oFWD_VALID = (r_state != ST_EMPTY) && w_young.wb;
    assign oFWD_DEST  = oFWD_VALID ? w_young.dest : '0;
    assign oFWD_DATA  = oFWD_VALID ? w_young.data : '0;

    // Sending while locked loses the beat; flush cycles are exempt since the beat is dropped anyway.
    a_no_overflow: assert property (@(posedge iCLOCK) disable iff (iRESET_SYNC)
        !(iPREVIOUS_VALID && oPREVIOUS_LOCK && !iFLUSH));

endmodule

// File: tb/tb_execute_result_skid.sv
// Scoreboard bench for execute_result_skid: accepted beats are queued, departures are
// popped and compared; occupancy, lock, FLAGS and forwarding are checked against the queue.
module tb_execute_result_skid;
    import core_pkg::*;

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic        flush   = 1'b0;
    logic        pv      = 1'b0;
    logic        plock;
    logic [31:0] pdata   = '0;
    logic [4:0]  pflags  = '0;
    logic [4:0]  pdest   = '0;
    logic        pwb     = 1'b0;
    logic        pfwb    = 1'b0;
    logic [31:0] ppc     = '0;
    logic        nvalid;
    logic        nlock   = 1'b0;
    logic [31:0] ndata;
    logic [4:0]  nflags;
    logic [4:0]  ndest;
    logic        nwb;
    logic        nfwb;
    logic [31:0] npc;
    logic [4:0]  flags_r;
    logic        fvalid;
    logic [4:0]  fdest;
    logic [31:0] fdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pc_ctr  = 0;
    exe_result_t sb_q[$];
    logic [4:0]  exp_flags = '0;
    bit          primed = 1'b0;

    always #5 clk_sys = ~clk_sys;

    execute_result_skid dut (
        .iCLOCK          (clk_sys),
        .iRESET_SYNC     (rst),
        .iFLUSH          (flush),
        .iPREVIOUS_VALID (pv),
        .oPREVIOUS_LOCK  (plock),
        .iPREVIOUS_DATA  (pdata),
        .iPREVIOUS_FLAGS (pflags),
        .iPREVIOUS_DEST  (pdest),
        .iPREVIOUS_WB    (pwb),
        .iPREVIOUS_FWB   (pfwb),
        .iPREVIOUS_PC    (ppc),
        .oNEXT_VALID     (nvalid),
        .iNEXT_LOCK      (nlock),
        .oNEXT_DATA      (ndata),
        .oNEXT_FLAGS     (nflags),
        .oNEXT_DEST      (ndest),
        .oNEXT_WB        (nwb),
        .oNEXT_FWB       (nfwb),
        .oNEXT_PC        (npc),
        .oFLAGS_R        (flags_r),
        .oFWD_VALID      (fvalid),
        .oFWD_DEST       (fdest),
        .oFWD_DATA       (fdata)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] f, input logic [4:0] dst,
                        input logic wb, input logic fwb);
        pv     = 1'b1;
        pdata  = d;
        pflags = f;
        pdest  = dst;
        pwb    = wb;
        pfwb   = fwb;
        ppc    = 32'h1000 + 32'(pc_ctr * 4);
        pc_ctr++;
    endtask

    // Model state at a falling edge equals DUT state after the preceding rising edge.
    always @(negedge clk_sys) begin
        exe_result_t e;
        logic        efv;
        if (primed) begin
            chk("next_valid", nvalid, sb_q.size() != 0);
            chk("prev_lock", plock, sb_q.size() == 2);
            chk("flags_r", flags_r, exp_flags);
            efv = (sb_q.size() != 0) && sb_q[$].wb;
            chk("fwd_valid", fvalid, efv);
            chk("fwd_dest", fdest, efv ? sb_q[$].dest : 5'd0);
            chk("fwd_data", fdata, efv ? sb_q[$].data : 32'd0);
        end
        if (rst) begin
            sb_q.delete();
            exp_flags = '0;
            primed    = 1'b1;
        end else if (primed) begin
            if (nvalid && !nlock) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_depart", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("next_payload", {ndata, nflags, ndest, nwb, nfwb, npc}, e);
                    if (e.fwb) exp_flags = e.flags;
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (pv && !plock) begin
                sb_q.push_back('{data: pdata, flags: pflags, dest: pdest,
                                 wb: pwb, fwb: pfwb, pc: ppc});
            end
        end
    end

    initial begin
        logic [63:0] prod;

        // reset held two cycles with upstream valid
        send(32'h5, 5'h1f, 5'd1, 1'b1, 1'b1);
        repeat (2) step();
        chk("rst_next_valid", nvalid, 0);
        chk("rst_prev_lock", plock, 0);
        chk("rst_flags", flags_r, 0);
        rst = 1'b0;
        pv  = 1'b0;
        step();

        // streaming: one beat per cycle, one cycle latency
        nlock = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            send(32'(i), 5'h0, 5'(i), 1'b1, 1'b0);
            step();
            chk("stream_data", ndata, 32'(i));
            chk("stream_lock", plock, 0);
        end
        pv = 1'b0;
        step();

        // skid: two beats into a stalled consumer
        nlock = 1'b1;
        send(32'h11, 5'h0, 5'd2, 1'b0, 1'b0);
        step();
        chk("skid_lock_a", plock, 0);
        send(32'h22, 5'h0, 5'd4, 1'b0, 1'b0);
        step();
        chk("skid_lock_b", plock, 1);
        chk("skid_head_a", ndata, 32'h11);
        pv = 1'b0;
        step();
        chk("skid_hold", plock, 1);
        nlock = 1'b0;
        step();
        chk("skid_head_b", ndata, 32'h22);
        chk("skid_unlock", plock, 0);
        step();
        chk("skid_empty", nvalid, 0);

        // FLAGS commit on FWB departure only
        prod = 64'hFFFF_FFFF * 64'd2;
        send(prod[31:0], 5'b10101, 5'd5, 1'b1, 1'b1);
        step();
        send(32'h0, 5'b01010, 5'd6, 1'b1, 1'b0);
        step();
        chk("flags_commit", flags_r, 5'b10101);
        pv = 1'b0;
        step();
        chk("flags_no_fwb", flags_r, 5'b10101);

        // flush of a full buffer with an incoming beat
        nlock = 1'b1;
        send(32'hC0, 5'b00011, 5'd3, 1'b1, 1'b1);
        step();
        send(32'hD0, 5'b00111, 5'd8, 1'b1, 1'b1);
        step();
        chk("flush_pre_full", plock, 1);
        send(32'hE0, 5'b01111, 5'd9, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        pv    = 1'b0;
        chk("flush_valid", nvalid, 0);
        chk("flush_lock", plock, 0);
        chk("flush_flags", flags_r, 5'b10101);
        chk("flush_fwd", fvalid, 0);

        // head departing in the flush cycle still commits
        nlock = 1'b0;
        send(32'h60, 5'b11111, 5'd10, 1'b0, 1'b1);
        step();
        pv    = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_commit", flags_r, 5'b11111);
        chk("flush_commit_valid", nvalid, 0);

        // reset mid-transfer drops the entry without committing
        send(32'h70, 5'b00110, 5'd11, 1'b1, 1'b1);
        step();
        pv  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_flags", flags_r, 0);
        chk("rst_mid_valid", nvalid, 0);

        // forwarding from the youngest entry
        nlock = 1'b1;
        send(32'h33, 5'h0, 5'd3, 1'b1, 1'b0);
        step();
        chk("fwd_head", fdest, 5'd3);
        send(32'h77, 5'h0, 5'd7, 1'b0, 1'b0);
        step();
        chk("fwd_skid_nowb", fvalid, 0);
        chk("fwd_skid_zero", fdata, 0);
        pv    = 1'b0;
        nlock = 1'b0;
        step();
        nlock = 1'b1;
        send(32'h99, 5'h0, 5'd9, 1'b1, 1'b0);
        step();
        chk("fwd_new_valid", fvalid, 1);
        chk("fwd_new_dest", fdest, 5'd9);
        chk("fwd_new_data", fdata, 32'h99);
        pv    = 1'b0;
        nlock = 1'b0;

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
        step();
        chk("drain_empty", sb_q.size(), 0);
        chk("drain_valid", nvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
